// File: rtl/loop_apu_sequencer_if.sv
// Instruction-queue push channel between loop_apu_sequencer and the queue.
// The sequencer uses the master modport and drives one decoded instruction
// with its resolved APU addresses and strides under valid/ready.
//   q_valid    : push valid (master -> slave)
//   q_ready    : queue can accept (slave -> master)
//   q_type     : instruction type, instr[15:14]
//   q_instr    : instr[13:0]
//   q_addr_a/b : current addresses of the two APUs selected by the instruction
//   q_stride_a/b : coefficient of those APUs for the innermost live loop
interface loop_apu_sequencer_if #(
    parameter int ADDR_W = 18
);
    logic              q_valid;
    logic              q_ready;
    logic [1:0]        q_type;
    logic [13:0]       q_instr;
    logic [ADDR_W-1:0] q_addr_a;
    logic [ADDR_W-1:0] q_addr_b;
    logic [ADDR_W-1:0] q_stride_a;
    logic [ADDR_W-1:0] q_stride_b;

    modport master (
        output q_valid, q_type, q_instr, q_addr_a, q_addr_b, q_stride_a, q_stride_b,
        input  q_ready
    );

    modport slave (
        input  q_valid, q_type, q_instr, q_addr_a, q_addr_b, q_stride_a, q_stride_b,
        output q_ready
    );
endinterface

// File: rtl/loop_apu_sequencer.sv
// Loop/address sequencer. Walks the program from start_pc to end_pc, retires
// loop instructions internally (loop stack + per-APU address registers) and
// pushes every non-loop instruction, with resolved addresses and strides,
// into the instruction queue.
//   clk, reset         : clock, asynchronous active-high reset
//   start/start_pc/end_pc : host program launch, accepted only when idle
//   busy/done/err      : host status; done pulses once, err qualifies it
//   pc/instr           : fetch address out, combinational instruction back
//   cfg_we/sel/idx/data: configuration writes (coef, base, loop total, jump)
//   q                  : queue push channel (master side)
module loop_apu_sequencer #(
    parameter int ADDR_W    = 18,
    parameter int LOG_LOOPS = 3,
    parameter int LOG_APUS  = 3,
    parameter int LOG_SS    = 3,
    parameter int PC_W      = 16,
    parameter int JMP_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [PC_W-1:0]               start_pc,
    input  logic [PC_W-1:0]               end_pc,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [PC_W-1:0]               pc,
    input  logic [15:0]                   instr,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_sel,
    input  logic [LOG_APUS+LOG_LOOPS-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]             cfg_data,
    loop_apu_sequencer_if.master          q
);
    localparam int LOOPS = 1 << LOG_LOOPS;
    localparam int APUS  = 1 << LOG_APUS;
    localparam int SS    = 1 << LOG_SS;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_LSTART = 4'd2;
    localparam logic [3:0] S_LSTEP  = 4'd3;
    localparam logic [3:0] S_APU    = 4'd4;
    localparam logic [3:0] S_EMIT   = 4'd5;
    localparam logic [3:0] S_ADV    = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERROR  = 4'd8;

    localparam logic [LOG_LOOPS:0] CNT_ZERO = {(LOG_LOOPS+1){1'b0}};
    localparam logic [LOG_LOOPS:0] CNT_ONE  = {{LOG_LOOPS{1'b0}}, 1'b1};
    localparam logic [LOG_LOOPS:0] CNT_FULL = {1'b1, {LOG_LOOPS{1'b0}}};
    localparam logic [PC_W-1:0]    PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]  A_ZERO   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]  A_SS     = ADDR_W'(SS);

    logic [3:0]           state_q, state_d;
    logic [PC_W-1:0]      pc_q, end_pc_q;
    logic                 busy_q, done_q, err_q;
    // Live stack entries; 0 corresponds to depth -1 (empty).
    logic [LOG_LOOPS:0]   cnt_q;
    logic                 lp_indep_q;
    logic [LOG_LOOPS-1:0] lp_ro_q;
    logic [LOG_LOOPS-1:0] lp_name_q;
    logic [ADDR_W-1:0]    di_q;
    logic [LOG_LOOPS-1:0] upd_name_q;

    logic [ADDR_W-1:0]    stk_val_q   [LOOPS];
    logic [ADDR_W-1:0]    stk_total_q [LOOPS];
    logic [JMP_W-1:0]     stk_jump_q  [LOOPS];
    logic                 stk_indep_q [LOOPS];
    logic [LOG_LOOPS-1:0] stk_name_q  [LOOPS];

    logic [ADDR_W-1:0]    coef_q     [APUS][LOOPS];
    logic [ADDR_W-1:0]    base_q     [APUS];
    logic [ADDR_W-1:0]    addr_q     [APUS];
    logic [ADDR_W-1:0]    ro_total_q [LOOPS];
    logic [JMP_W-1:0]     ro_jump_q  [LOOPS];

    logic                 q_valid_q;
    logic [1:0]           q_type_q;
    logic [13:0]          q_instr_q;
    logic [ADDR_W-1:0]    q_addr_a_q, q_addr_b_q, q_stride_a_q, q_stride_b_q;

    logic [LOG_LOOPS:0]   top_full_s;
    logic [LOG_LOOPS-1:0] top_s;
    logic                 empty_s;
    logic [ADDR_W-1:0]    rem_s, step_s;
    logic [ADDR_W:0]      sum_s;
    logic                 cont_s;
    logic [LOG_APUS-1:0]  dec_a_s, dec_b_s;
    logic [ADDR_W-1:0]    apu_next_s [APUS];
    logic [LOG_APUS-1:0]  cfg_apu_s;
    logic [LOG_LOOPS-1:0] cfg_lp_s;

    assign top_full_s = cnt_q - CNT_ONE;
    assign top_s      = top_full_s[LOG_LOOPS-1:0];
    assign empty_s    = (cnt_q == CNT_ZERO);
    assign dec_a_s    = instr[11 +: LOG_APUS];
    assign dec_b_s    = instr[8 +: LOG_APUS];
    assign cfg_apu_s  = cfg_idx[LOG_APUS+LOG_LOOPS-1 -: LOG_APUS];
    assign cfg_lp_s   = cfg_idx[LOG_LOOPS-1:0];

    // Iteration step of the innermost loop: independent loops retire up to SS at once.
    always_comb begin
        rem_s  = stk_total_q[top_s] - stk_val_q[top_s];
        step_s = A_ONE;
        if (stk_indep_q[top_s]) begin
            step_s = (rem_s < A_SS) ? rem_s : A_SS;
        end else begin
            step_s = A_ONE;
        end
        sum_s  = {1'b0, stk_val_q[top_s]} + {1'b0, step_s};
        cont_s = (sum_s < {1'b0, stk_total_q[top_s]});
    end

    // Next APU addresses; di is two's complement so the wrap-around is the intended result.
    always_comb begin
        for (int k = 0; k < APUS; k++) begin
            apu_next_s[k] = addr_q[k] + di_q * coef_q[k][upd_name_q];
        end
    end

    // FSM next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DECODE; else state_d = S_IDLE;
            S_DECODE: begin
                if (instr[15:14] == 2'b11) begin
                    if (instr[12]) state_d = S_LSTART; else state_d = S_LSTEP;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_LSTART: if (cnt_q == CNT_FULL) state_d = S_ERROR; else state_d = S_ADV;
            S_LSTEP:  if (empty_s) state_d = S_ERROR; else state_d = S_APU;
            S_APU:    state_d = S_ADV;
            S_EMIT:   if (q.q_ready) state_d = S_ADV; else state_d = S_EMIT;
            S_ADV:    if (pc_q > end_pc_q) state_d = S_DONE; else state_d = S_DECODE;
            S_DONE:   state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, datapath, loop stack, APU and configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= {PC_W{1'b0}};
            end_pc_q     <= {PC_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= CNT_ZERO;
            lp_indep_q   <= 1'b0;
            lp_ro_q      <= {LOG_LOOPS{1'b0}};
            lp_name_q    <= {LOG_LOOPS{1'b0}};
            di_q         <= A_ZERO;
            upd_name_q   <= {LOG_LOOPS{1'b0}};
            q_valid_q    <= 1'b0;
            q_type_q     <= 2'b00;
            q_instr_q    <= 14'h0000;
            q_addr_a_q   <= A_ZERO;
            q_addr_b_q   <= A_ZERO;
            q_stride_a_q <= A_ZERO;
            q_stride_b_q <= A_ZERO;
            for (int l = 0; l < LOOPS; l++) begin
                stk_val_q[l]   <= A_ZERO;
                stk_total_q[l] <= A_ZERO;
                stk_jump_q[l]  <= {JMP_W{1'b0}};
                stk_indep_q[l] <= 1'b0;
                stk_name_q[l]  <= {LOG_LOOPS{1'b0}};
                ro_total_q[l]  <= A_ZERO;
                ro_jump_q[l]   <= {JMP_W{1'b0}};
            end
            for (int k = 0; k < APUS; k++) begin
                base_q[k] <= A_ZERO;
                addr_q[k] <= A_ZERO;
                for (int l = 0; l < LOOPS; l++) begin
                    coef_q[k][l] <= A_ZERO;
                end
            end
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE) || (state_d == S_ERROR);
            if ((state_d == S_DONE) || (state_d == S_ERROR)) begin
                busy_q <= 1'b0;
            end
            if (state_d == S_ERROR) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cfg_we) begin
                        case (cfg_sel)
                            2'd0:    coef_q[cfg_apu_s][cfg_lp_s] <= cfg_data;
                            2'd1:    base_q[cfg_apu_s]           <= cfg_data;
                            2'd2:    ro_total_q[cfg_lp_s]        <= cfg_data;
                            2'd3:    ro_jump_q[cfg_lp_s]         <= cfg_data[JMP_W-1:0];
                            default: ro_jump_q[cfg_lp_s]         <= ro_jump_q[cfg_lp_s];
                        endcase
                    end
                    if (start) begin
                        pc_q     <= start_pc;
                        end_pc_q <= end_pc;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        cnt_q    <= CNT_ZERO;
                        for (int k = 0; k < APUS; k++) begin
                            addr_q[k] <= base_q[k];
                        end
                    end
                end
                S_DECODE: begin
                    lp_indep_q <= instr[13];
                    lp_ro_q    <= instr[9 +: LOG_LOOPS];
                    lp_name_q  <= instr[6 +: LOG_LOOPS];
                    if (instr[15:14] != 2'b11) begin
                        q_valid_q    <= 1'b1;
                        q_type_q     <= instr[15:14];
                        q_instr_q    <= instr[13:0];
                        q_addr_a_q   <= addr_q[dec_a_s];
                        q_addr_b_q   <= addr_q[dec_b_s];
                        q_stride_a_q <= empty_s ? A_ZERO : coef_q[dec_a_s][stk_name_q[top_s]];
                        q_stride_b_q <= empty_s ? A_ZERO : coef_q[dec_b_s][stk_name_q[top_s]];
                    end
                end
                S_LSTART: begin
                    if (cnt_q != CNT_FULL) begin
                        stk_val_q[cnt_q[LOG_LOOPS-1:0]]   <= A_ZERO;
                        stk_total_q[cnt_q[LOG_LOOPS-1:0]] <= ro_total_q[lp_ro_q];
                        stk_jump_q[cnt_q[LOG_LOOPS-1:0]]  <= ro_jump_q[lp_ro_q];
                        stk_indep_q[cnt_q[LOG_LOOPS-1:0]] <= lp_indep_q;
                        stk_name_q[cnt_q[LOG_LOOPS-1:0]]  <= lp_name_q;
                        cnt_q <= cnt_q + CNT_ONE;
                        pc_q  <= pc_q + PC_ONE;
                    end
                end
                S_LSTEP: begin
                    if (!empty_s) begin
                        upd_name_q <= stk_name_q[top_s];
                        if (cont_s) begin
                            stk_val_q[top_s] <= sum_s[ADDR_W-1:0];
                            di_q <= step_s;
                            pc_q <= pc_q - {{(PC_W-JMP_W){1'b0}}, stk_jump_q[top_s]};
                        end else begin
                            // Loop exhausted: rewind APUs to their value at loop entry.
                            di_q  <= ~stk_val_q[top_s] + A_ONE;
                            cnt_q <= top_full_s;
                            pc_q  <= pc_q + PC_ONE;
                        end
                    end
                end
                S_APU: begin
                    for (int k = 0; k < APUS; k++) begin
                        addr_q[k] <= apu_next_s[k];
                    end
                end
                S_EMIT: begin
                    if (q.q_ready) begin
                        q_valid_q <= 1'b0;
                        pc_q      <= pc_q + PC_ONE;
                    end
                end
                default: begin
                    pc_q <= pc_q;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign pc           = pc_q;
    assign q.q_valid    = q_valid_q;
    assign q.q_type     = q_type_q;
    assign q.q_instr    = q_instr_q;
    assign q.q_addr_a   = q_addr_a_q;
    assign q.q_addr_b   = q_addr_b_q;
    assign q.q_stride_a = q_stride_a_q;
    assign q.q_stride_b = q_stride_b_q;
endmodule

// File: tb/tb_loop_apu_sequencer.sv
// Self-checking bench for loop_apu_sequencer: a table of single-instruction
// programs plus hand-written loop, stall, error and reset sequences. Expected
// queue pushes are queued when a program is launched and compared by a
// monitor whenever the DUT hands a push over.
module tb_loop_apu_sequencer;
    typedef struct {
        logic [1:0]  ty;
        logic [13:0] ins;
        logic [17:0] a, b, sa, sb;
        bit          ca, cb;
    } push_t;

    typedef struct {
        logic [15:0] pcv;
        logic [15:0] ins;
        push_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_pc = 16'h0000;
    logic [15:0] end_pc = 16'h0000;
    logic        busy, done, err;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [5:0]  cfg_idx = 6'd0;
    logic [17:0] cfg_data = 18'd0;
    logic [15:0] prog [256];

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int push_cnt = 0;
    push_t exp_q[$];

    loop_apu_sequencer_if #(.ADDR_W(18)) qif();

    loop_apu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .end_pc(end_pc),
        .busy(busy), .done(done), .err(err), .pc(pc), .instr(instr),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .q(qif)
    );

    assign instr = prog[pc[7:0]];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic push_t mk(input logic [1:0] ty, input logic [13:0] ins,
                                 input logic [17:0] a, input logic [17:0] b,
                                 input logic [17:0] sa, input logic [17:0] sb,
                                 input bit ca, input bit cb);
        push_t p;
        p.ty = ty; p.ins = ins; p.a = a; p.b = b; p.sa = sa; p.sb = sb; p.ca = ca; p.cb = cb;
        return p;
    endfunction

    // Scoreboard: compare each accepted push against the oldest expectation.
    always @(negedge clk) begin
        push_t e;
        if (qif.q_valid === 1'b1 && qif.q_ready === 1'b1) begin
            push_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_push", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("q_type", {30'd0, qif.q_type}, {30'd0, e.ty});
                chk("q_instr", {18'd0, qif.q_instr}, {18'd0, e.ins});
                if (e.ca) chk("q_addr_a", {14'd0, qif.q_addr_a}, {14'd0, e.a});
                if (e.cb) chk("q_addr_b", {14'd0, qif.q_addr_b}, {14'd0, e.b});
                chk("q_stride_a", {14'd0, qif.q_stride_a}, {14'd0, e.sa});
                chk("q_stride_b", {14'd0, qif.q_stride_b}, {14'd0, e.sb});
            end
        end
    end

    task automatic cfg_write(input logic [1:0] sel, input logic [5:0] idx, input logic [17:0] data);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_prog(input logic [15:0] spc, input logic [15:0] epc);
        @(posedge clk); #1;
        start = 1'b1; start_pc = spc; end_pc = epc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input logic exp_err);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("err_at_done", {31'd0, err}, {31'd0, exp_err});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("done_pulse_width", {31'd0, done}, 32'd0);
        chk("err_hold", {31'd0, err}, {31'd0, exp_err});
        chk("pushes_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Coefficient model: coef[k][l] = 4*(k+1)+l, base[k] = 100+1000*k.
    function automatic logic [17:0] coef(input int k, input int l);
        return 18'(4 * (k + 1) + l);
    endfunction
    function automatic logic [17:0] base(input int k);
        return 18'(100 + 1000 * k);
    endfunction

    initial begin
        vec_t vt [7];
        int   p0;
        int   cyc;

        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        qif.q_ready = 1'b1;

        vt[0] = '{pcv: 16'd5,   ins: 16'hB234, exp: mk(2'd2, 14'h3234, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0)};
        vt[1] = '{pcv: 16'd9,   ins: 16'h1055, exp: mk(2'd0, 14'h1055, base(2), 18'd0, 18'd0, 18'd0, 1'b1, 1'b0)};
        vt[2] = '{pcv: 16'd100, ins: 16'h7B34, exp: mk(2'd1, 14'h3B34, base(7), base(3), 18'd0, 18'd0, 1'b1, 1'b1)};
        vt[3] = '{pcv: 16'd0,   ins: 16'h45FF, exp: mk(2'd1, 14'h05FF, base(0), base(5), 18'd0, 18'd0, 1'b1, 1'b1)};
        vt[4] = '{pcv: 16'd254, ins: 16'h2FFF, exp: mk(2'd0, 14'h2FFF, base(5), 18'd0, 18'd0, 18'd0, 1'b1, 1'b0)};
        vt[5] = '{pcv: 16'd17,  ins: 16'hBFFF, exp: mk(2'd2, 14'h3FFF, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0)};
        vt[6] = '{pcv: 16'd60,  ins: 16'h7600, exp: mk(2'd1, 14'h3600, base(6), base(6), 18'd0, 18'd0, 1'b1, 1'b1)};

        // Reset state.
        reset = 1'b1;
        #12;
        chk("rst_pc", {16'd0, pc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_q_valid", {31'd0, qif.q_valid}, 32'd0);
        chk("rst_q_addr_a", {14'd0, qif.q_addr_a}, 32'd0);
        reset = 1'b0;

        // Configuration.
        for (int k = 0; k < 8; k++) begin
            cfg_write(2'd1, {3'(k), 3'd0}, base(k));
            for (int l = 0; l < 8; l++) cfg_write(2'd0, {3'(k), 3'(l)}, coef(k, l));
        end
        cfg_write(2'd2, 6'd0, 18'd3);  cfg_write(2'd3, 6'd0, 18'd1);
        cfg_write(2'd2, 6'd1, 18'd11); cfg_write(2'd3, 6'd1, 18'd1);
        cfg_write(2'd2, 6'd2, 18'd0);  cfg_write(2'd3, 6'd2, 18'd1);

        // Table: one non-loop instruction per program, start_pc == end_pc.
        for (int v = 0; v < 7; v++) begin
            prog[vt[v].pcv[7:0]] = vt[v].ins;
            exp_q.push_back(vt[v].exp);
            start_prog(vt[v].pcv, vt[v].pcv);
            wait_done(1'b0);
        end

        // Backpressure: q_* and pc frozen while q_ready is low, one push only.
        prog[5] = 16'h7B34;
        qif.q_ready = 1'b0;
        exp_q.push_back(mk(2'd1, 14'h3B34, base(7), base(3), 18'd0, 18'd0, 1'b1, 1'b1));
        p0 = push_cnt;
        start_prog(16'd5, 16'd5);
        cyc = 0;
        while (qif.q_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {31'd0, qif.q_valid}, 32'd1);
            chk("stall_pc", {16'd0, pc}, 32'd5);
            chk("stall_addr_a", {14'd0, qif.q_addr_a}, {14'd0, base(7)});
            chk("stall_addr_b", {14'd0, qif.q_addr_b}, {14'd0, base(3)});
            chk("stall_instr", {18'd0, qif.q_instr}, 32'h3B34);
            @(posedge clk); #1;
        end
        qif.q_ready = 1'b1;
        wait_done(1'b0);
        chk("stall_push_count", push_cnt - p0, 32'd1);

        // Dependent loop total=3 on loop name 0, then APU0 back at its base.
        prog[5] = 16'hD000; prog[6] = 16'h0000; prog[7] = 16'hC000; prog[8] = 16'h0000;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk(2'd0, 14'h0000, base(0) + 18'(i) * coef(0, 0), 18'd0, coef(0, 0), coef(0, 0), 1'b1, 1'b0));
        exp_q.push_back(mk(2'd0, 14'h0000, base(0), 18'd0, 18'd0, 18'd0, 1'b1, 1'b0));
        start_prog(16'd5, 16'd8);
        wait_done(1'b0);

        // Independent loop total=11: steps of 8 then 3, two body passes.
        prog[20] = 16'hF240; prog[21] = 16'h0800; prog[22] = 16'hC000; prog[23] = 16'h0800;
        exp_q.push_back(mk(2'd0, 14'h0800, base(1), 18'd0, coef(1, 1), coef(0, 1), 1'b1, 1'b0));
        exp_q.push_back(mk(2'd0, 14'h0800, base(1) + 18'd8 * coef(1, 1), 18'd0, coef(1, 1), coef(0, 1), 1'b1, 1'b0));
        exp_q.push_back(mk(2'd0, 14'h0800, base(1), 18'd0, 18'd0, 18'd0, 1'b1, 1'b0));
        start_prog(16'd20, 16'd23);
        wait_done(1'b0);

        // total=0 loop: body once, exit with no address movement.
        prog[30] = 16'hD480; prog[31] = 16'h5200; prog[32] = 16'hC000; prog[33] = 16'h1000;
        exp_q.push_back(mk(2'd1, 14'h1200, base(2), base(2), coef(2, 2), coef(2, 2), 1'b1, 1'b1));
        exp_q.push_back(mk(2'd0, 14'h1000, base(2), 18'd0, 18'd0, 18'd0, 1'b1, 1'b0));
        start_prog(16'd30, 16'd33);
        wait_done(1'b0);

        // Stack overflow: ninth nested LOOP_START.
        for (int i = 40; i < 49; i++) prog[i] = 16'hD000;
        start_prog(16'd40, 16'd48);
        wait_done(1'b1);

        // Stack underflow: LOOP_STEP with nothing live.
        prog[50] = 16'hC000;
        start_prog(16'd50, 16'd50);
        wait_done(1'b1);

        // err cleared by the next accepted start.
        prog[5] = 16'hB234;
        exp_q.push_back(mk(2'd2, 14'h3234, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0));
        start_prog(16'd5, 16'd5);
        chk("err_cleared_by_start", {31'd0, err}, 32'd0);
        wait_done(1'b0);

        // Async reset while a push is pending.
        qif.q_ready = 1'b0;
        exp_q.push_back(mk(2'd2, 14'h3234, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0));
        start_prog(16'd5, 16'd5);
        cyc = 0;
        while (qif.q_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        chk("pre_reset_valid", {31'd0, qif.q_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("reset_q_valid", {31'd0, qif.q_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        qif.q_ready = 1'b1;
        exp_q.push_back(mk(2'd2, 14'h3234, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0));
        start_prog(16'd5, 16'd5);
        wait_done(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
